regn_piso_tx: RTL and testbench
===============================

// Module: regn_piso_tx
// PURPOSE
//  Parallel-in/serial-out transmitter: unloads an n-bit word (e.g. the output of a
//  parallel-load register) and sends it one bit per accepted beat over a
//  valid/ready serial link. It is the draining end of the parallel-load datapath.
//  Back-to-back words stream with no idle bubble.
// PARAMETERS
//  n          32  word width in bits (n >= 1)
//  MSB_FIRST  1   1: bit n-1 is sent first; 0: bit 0 is sent first
// PORTS
//  clk       in   1   rising-edge clock; the single clock domain
//  rst       in   1   asynchronous reset, active-high
//  di        in   n   parallel word to send
//  di_valid  in   1   di is valid this cycle
//  di_ready  out  1   block accepts di this cycle
//  so        out  1   current serial bit
//  so_valid  out  1   so is valid
//  so_ready  in   1   downstream accepts so this cycle
//  done      out  1   one-cycle pulse: last bit of a word accepted
// BEHAVIOUR
//  Interface: one clock (clk); reset rst is asynchronous and active-high.
//  Reset values: state=IDLE, shreg=0, cnt=0, so=0, so_valid=0, done=0, di_ready=1.
//  Reset mid-word abandons the word: no done pulse, no further bits.
//  States
//   IDLE:  so_valid=0, di_ready=1. di_valid&di_ready at the edge:
//          shreg<=di, cnt<=n-1, go to SHIFT.
//   SHIFT: so_valid=1, so=shreg[n-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0).
//          Beat = so_valid&so_ready at the edge. On a beat with cnt>0: shift shreg
//          by one toward the output end (zero fill) and decrement cnt.
//          On a beat with cnt==0: done<=1 for one cycle. If di_valid also holds,
//          load the new word and stay in SHIFT. Otherwise go to IDLE.
//  di_ready = (state==IDLE) | (state==SHIFT & cnt==0 & so_ready). This is
//   combinational from state and so_ready, with no path from di_valid.
//  so and so_valid are driven from registers only.
//  so_ready low: shreg, cnt and so hold. so_valid stays 1 and never retracts.
//  di_valid while di_ready=0: ignored. Upstream must hold di stable.
//  Latency: the first bit is on so in the cycle after the load edge.
//   Word time = n beats. Streaming throughput = 1 bit/clk when so_ready=1.
//  n=1: cnt is fixed at 0. Each word is one beat, and done fires on every beat.
//  cnt width = max(1, $clog2(n)). cnt never wraps below 0.
// STRUCTURE
//  Shared package piso_pkg:
//   - state encodings S_IDLE=1'b0 and S_SHIFT=1'b1
//   - function cnt_w(n) = max(1, $clog2(n))
//  One sub-module: cnt_down. It is a loadable down-counter (load value, dec enable)
//  and reports zero. The FSM and shift register stay in regn_piso_tx.
// TESTING  (n=8 unless stated)
//  Reset: assert rst asynchronously mid-cycle -> so_valid=0, di_ready=1,
//   done=0 immediately.
//  Word: di=8'hA5, so_ready=1, MSB_FIRST=1 -> so=1,0,1,0,0,1,0,1 on 8 cycles;
//   done on the 8th beat.
//  LSB first: MSB_FIRST=0, di=8'h01 -> first bit 1, then seven 0s.
//  Backpressure: drop so_ready for 3 cycles after bit 2 -> so holds, cnt holds,
//   stream resumes intact.
//  Stream: di=8'hF0 then 8'h0F, di_valid held -> 16 contiguous beats, no bubble,
//   two done pulses.
//  Abort: rst after 4 bits of 8'hFF -> no done. Next word 8'h3C is sent
//   correctly from its first bit.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter:
// FSM state encodings and the bit-counter width rule.
package piso_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // A word of n bits needs a counter holding n-1 down to 0; keep at least one bit for n=1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnt_down.sv
// Loadable down-counter that saturates at zero and flags when it is there.
module cnt_down #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load has priority so a new word can start on the same edge the old one finishes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/regn_piso_tx.sv
// Parallel-in/serial-out transmitter: takes an n-bit word over valid/ready and
// streams it one bit per accepted beat, back-to-back words without a bubble.
module regn_piso_tx
    import piso_pkg::*;
#(
    parameter int n         = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] di,
    input  logic         di_valid,
    output logic         di_ready,
    output logic         so,
    output logic         so_valid,
    input  logic         so_ready,
    output logic         done
);

    localparam int CW = cnt_w(n);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [n-1:0] r_shreg;
    logic [n-1:0] w_shifted;
    logic         r_done;
    logic         w_cnt_zero;
    logic         w_beat;
    logic         w_last_beat;
    logic         w_load;

    assign so_valid    = (r_state == S_SHIFT);
    assign so          = MSB_FIRST ? r_shreg[n-1] : r_shreg[0];
    assign w_beat      = so_valid & so_ready;
    assign w_last_beat = w_beat & w_cnt_zero;
    // Ready may rise on the final beat so the next word loads with no idle cycle.
    assign di_ready    = (r_state == S_IDLE) |
                         ((r_state == S_SHIFT) & w_cnt_zero & so_ready);
    assign w_load      = di_valid & di_ready;
    assign w_shifted   = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
    assign done        = r_done;

    cnt_down #(
        .W(CW)
    ) u_cnt (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_load),
        .i_load_val (CW'(n - 1)),
        .i_dec      (w_beat),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (di_valid) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last_beat && !di_valid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last_beat;
            if (w_load) begin
                r_shreg <= di;
            end else if (w_beat && !w_cnt_zero) begin
                r_shreg <= w_shifted;
            end
        end
    end

endmodule

// File: tb/tb_regn_piso_tx.sv
// Scoreboard bench for regn_piso_tx: MSB-first, LSB-first (n=8) and n=1 instances.
module tb_regn_piso_tx;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] di;
    logic         di_valid, so_ready;
    logic         di_ready_m, so_m, so_valid_m, done_m;
    logic         di_ready_l, so_l, so_valid_l, done_l;
    logic [0:0]   di1;
    logic         di1_valid, di_ready_1, so_1, so_valid_1, done_1;

    always #5 clk = ~clk;

    regn_piso_tx #(.n(N), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .di(di), .di_valid(di_valid), .di_ready(di_ready_m),
        .so(so_m), .so_valid(so_valid_m), .so_ready(so_ready), .done(done_m));

    regn_piso_tx #(.n(N), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .di(di), .di_valid(di_valid), .di_ready(di_ready_l),
        .so(so_l), .so_valid(so_valid_l), .so_ready(so_ready), .done(done_l));

    regn_piso_tx #(.n(1), .MSB_FIRST(1'b1)) dut_1 (
        .clk(clk), .rst(rst), .di(di1), .di_valid(di1_valid), .di_ready(di_ready_1),
        .so(so_1), .so_valid(so_valid_1), .so_ready(so_ready), .done(done_1));

    int   checks = 0, failures = 0;
    logic exp_m[$], exp_l[$], exp_1[$], obs_m[$], obs_l[$], obs_1[$];
    int   nd_m, nd_l, nd_1, nbeat, cyc, first_beat, last_beat, last_done;
    logic acc, acc1;

    // Sample on the falling edge, then step past the rising edge.
    task automatic tick;
        @(negedge clk);
        acc  = di_valid && di_ready_m;
        acc1 = di1_valid && di_ready_1;
        if (so_valid_m && so_ready) begin
            obs_m.push_back(so_m);
            if (nbeat == 0) first_beat = cyc;
            last_beat = cyc;
            nbeat++;
        end
        if (so_valid_l && so_ready) obs_l.push_back(so_l);
        if (so_valid_1 && so_ready) obs_1.push_back(so_1);
        if (done_m) begin nd_m++; last_done = cyc; end
        if (done_l) nd_l++;
        if (done_1) nd_1++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_sb;
        exp_m.delete(); exp_l.delete(); exp_1.delete();
        obs_m.delete(); obs_l.delete(); obs_1.delete();
        nd_m = 0; nd_l = 0; nd_1 = 0; nbeat = 0; last_done = -1;
    endtask

    task automatic push_word(input logic [N-1:0] w);
        for (int i = N - 1; i >= 0; i--) exp_m.push_back(w[i]);
        for (int i = 0; i < N; i++) exp_l.push_back(w[i]);
    endtask

    task automatic load(input logic [N-1:0] w);
        di = w;
        di_valid = 1'b1;
        push_word(w);
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) tick;
        if (!acc) begin
            checks++; failures++;
            $display("FAIL load_timeout word=%h not accepted within 20 cycles", w);
        end
        di_valid = 1'b0;
    endtask

    task automatic drain(input int k);
        repeat (k) tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; di = '0; di_valid = 1'b0; so_ready = 1'b1;
        di1 = '0; di1_valid = 1'b0; cyc = 0;
        clear_sb;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (so_valid_m !== 1'b0) begin failures++; $display("FAIL rst_so_valid got %b want 0", so_valid_m); end
        checks++; if (di_ready_m !== 1'b1) begin failures++; $display("FAIL rst_di_ready got %b want 1", di_ready_m); end
        checks++; if (done_m !== 1'b0) begin failures++; $display("FAIL rst_done got %b want 0", done_m); end
        checks++; if (so_m !== 1'b0) begin failures++; $display("FAIL rst_so got %b want 0", so_m); end
        checks++; if (so_valid_1 !== 1'b0) begin failures++; $display("FAIL rst_so_valid_n1 got %b want 0", so_valid_1); end
        rst = 1'b0;
        drain(2);
        checks++; if (so_valid_m !== 1'b0 || nd_m != 0) begin failures++; $display("FAIL idle_after_rst so_valid=%b done_cnt=%0d want 0/0", so_valid_m, nd_m); end
    endtask

    task automatic test_word;
        logic e, o;
        clear_sb;
        so_ready = 1'b1;
        load(8'hA5);
        checks++; if (so_valid_m !== 1'b1 || so_m !== 1'b1) begin failures++; $display("FAIL word_first_bit valid=%b so=%b want 1/1", so_valid_m, so_m); end
        drain(12);
        while (exp_m.size() > 0) begin
            e = exp_m.pop_front(); o = (obs_m.size() > 0) ? obs_m.pop_front() : 1'bx;
            checks++; if (o !== e) begin failures++; $display("FAIL word_msb_bit got %b want %b", o, e); end
        end
        while (exp_l.size() > 0) begin
            e = exp_l.pop_front(); o = (obs_l.size() > 0) ? obs_l.pop_front() : 1'bx;
            checks++; if (o !== e) begin failures++; $display("FAIL word_lsb_bit got %b want %b", o, e); end
        end
        checks++; if (nbeat != 8 || last_beat - first_beat != 7) begin failures++; $display("FAIL word_beats got %0d span %0d want 8/7", nbeat, last_beat - first_beat); end
        checks++; if (nd_m != 1 || nd_l != 1) begin failures++; $display("FAIL word_done_count got %0d/%0d want 1/1", nd_m, nd_l); end
        checks++; if (last_done != last_beat + 1) begin failures++; $display("FAIL word_done_timing got cyc %0d want %0d", last_done, last_beat + 1); end
    endtask

    task automatic test_lsb_first;
        logic e, o;
        clear_sb;
        load(8'h01);
        checks++; if (so_l !== 1'b1) begin failures++; $display("FAIL lsb_first_bit got %b want 1", so_l); end
        drain(12);
        while (exp_l.size() > 0) begin
            e = exp_l.pop_front(); o = (obs_l.size() > 0) ? obs_l.pop_front() : 1'bx;
            checks++; if (o !== e) begin failures++; $display("FAIL lsb_bit got %b want %b", o, e); end
        end
        while (exp_m.size() > 0) begin
            e = exp_m.pop_front(); o = (obs_m.size() > 0) ? obs_m.pop_front() : 1'bx;
            checks++; if (o !== e) begin failures++; $display("FAIL lsb_msbdut_bit got %b want %b", o, e); end
        end
        checks++; if (obs_l.size() != 0 || nd_l != 1) begin failures++; $display("FAIL lsb_extra_or_done extra=%0d done=%0d want 0/1", obs_l.size(), nd_l); end
    endtask

    task automatic test_backpressure;
        logic e, o, hold;
        logic [2:0] hcnt;
        clear_sb;
        load(8'h96);
        for (int k = 0; k < 20 && nbeat < 2; k++) tick;
        checks++; if (nbeat != 2) begin failures++; $display("FAIL bp_reach_bit2 got %0d beats want 2", nbeat); end
        so_ready = 1'b0;
        hold = so_m;
        hcnt = dut_m.u_cnt.r_cnt;
        checks++; if (hcnt !== 3'd5) begin failures++; $display("FAIL bp_cnt_before got %0d want 5", hcnt); end
        repeat (3) begin
            tick;
            checks++; if (so_m !== hold || so_valid_m !== 1'b1) begin failures++; $display("FAIL bp_hold so=%b valid=%b want %b/1", so_m, so_valid_m, hold); end
            checks++; if (dut_m.u_cnt.r_cnt !== 3'd5 || di_ready_m !== 1'b0) begin failures++; $display("FAIL bp_cnt_hold cnt=%0d di_ready=%b want 5/0", dut_m.u_cnt.r_cnt, di_ready_m); end
        end
        so_ready = 1'b1;
        drain(12);
        while (exp_m.size() > 0) begin
            e = exp_m.pop_front(); o = (obs_m.size() > 0) ? obs_m.pop_front() : 1'bx;
            checks++; if (o !== e) begin failures++; $display("FAIL bp_bit got %b want %b", o, e); end
        end
        checks++; if (obs_m.size() != 0 || nd_m != 1) begin failures++; $display("FAIL bp_extra_or_done extra=%0d done=%0d want 0/1", obs_m.size(), nd_m); end
    endtask

    task automatic test_back_to_back;
        logic e, o;
        clear_sb;
        di = 8'hF0; di_valid = 1'b1; push_word(8'hF0);
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) tick;
        di = 8'h0F; push_word(8'h0F);
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) tick;
        checks++; if (!acc) begin failures++; $display("FAIL stream_second_accept got 0 want 1"); end
        di_valid = 1'b0;
        drain(12);
        while (exp_m.size() > 0) begin
            e = exp_m.pop_front(); o = (obs_m.size() > 0) ? obs_m.pop_front() : 1'bx;
            checks++; if (o !== e) begin failures++; $display("FAIL stream_bit got %b want %b", o, e); end
        end
        checks++; if (nbeat != 16 || last_beat - first_beat != 15) begin failures++; $display("FAIL stream_contig beats=%0d span=%0d want 16/15", nbeat, last_beat - first_beat); end
        checks++; if (nd_m != 2) begin failures++; $display("FAIL stream_done_count got %0d want 2", nd_m); end
    endtask

    task automatic test_n1;
        logic e, o;
        logic bits [3] = '{1'b1, 1'b0, 1'b1};
        clear_sb;
        for (int b = 0; b < 3; b++) begin
            di1 = bits[b]; di1_valid = 1'b1; exp_1.push_back(bits[b]);
            acc1 = 1'b0;
            for (int k = 0; k < 20 && !acc1; k++) tick;
        end
        di1_valid = 1'b0;
        drain(4);
        while (exp_1.size() > 0) begin
            e = exp_1.pop_front(); o = (obs_1.size() > 0) ? obs_1.pop_front() : 1'bx;
            checks++; if (o !== e) begin failures++; $display("FAIL n1_bit got %b want %b", o, e); end
        end
        checks++; if (nd_1 != 3) begin failures++; $display("FAIL n1_done_count got %0d want 3", nd_1); end
    endtask

    task automatic test_abort;
        logic e, o;
        clear_sb;
        load(8'hFF);
        for (int k = 0; k < 20 && nbeat < 4; k++) tick;
        checks++; if (obs_m.size() != 4) begin failures++; $display("FAIL abort_pre_bits got %0d want 4", obs_m.size()); end
        foreach (obs_m[i]) begin
            checks++; if (obs_m[i] !== 1'b1) begin failures++; $display("FAIL abort_pre_bit got %b want 1", obs_m[i]); end
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (so_valid_m !== 1'b0 || di_ready_m !== 1'b1 || done_m !== 1'b0) begin
            failures++; $display("FAIL async_rst valid=%b ready=%b done=%b want 0/1/0", so_valid_m, di_ready_m, done_m);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        clear_sb;
        drain(12);
        checks++; if (nd_m != 0 || nbeat != 0) begin failures++; $display("FAIL abort_residue done=%0d beats=%0d want 0/0", nd_m, nbeat); end
        load(8'h3C);
        drain(12);
        while (exp_m.size() > 0) begin
            e = exp_m.pop_front(); o = (obs_m.size() > 0) ? obs_m.pop_front() : 1'bx;
            checks++; if (o !== e) begin failures++; $display("FAIL abort_next_bit got %b want %b", o, e); end
        end
        checks++; if (nd_m != 1) begin failures++; $display("FAIL abort_next_done got %0d want 1", nd_m); end
    endtask

    initial begin
        test_reset;
        test_word;
        test_lsb_first;
        test_backpressure;
        test_back_to_back;
        test_n1;
        test_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
